// File: rtl/mult_div_unit.sv
// Iterative shift-add multiply / restoring divide producing {hi, lo}.
// Define MDU_SIGNED_EN to honour op_signed (magnitude/negation logic).
module mult_div_unit #(
    parameter int DATA_BITS = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   op_div,
    input  logic                   op_signed,
    input  logic [DATA_BITS-1:0]   a,
    input  logic [DATA_BITS-1:0]   b,
    output logic                   busy,
    output logic                   ready,
    output logic [2*DATA_BITS-1:0] result
);

    localparam int W  = DATA_BITS;
    localparam int CW = $clog2(DATA_BITS) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [W-1:0]     opnd_q, opnd_d;
    logic [2*W-1:0]   result_q, result_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;

    logic [W-1:0]     mag_a, mag_b;
    logic [W:0]       mul_sum;
    logic [W:0]       div_shift, div_diff;
    logic [2*W-1:0]   step, fixed;
    logic             accept;

`ifdef MDU_SIGNED_EN
    logic div_q, div_d;
    logic neg_q, neg_d;
    logic rneg_q, rneg_d;
    logic sa, sb;
`else
    logic unused_sign;
    assign unused_sign = op_signed;
`endif

    // Operand magnitudes, one RUN iteration and FIX-stage correction
    always_comb begin
        mag_a = a;
        mag_b = b;
`ifdef MDU_SIGNED_EN
        sa = op_signed & a[W-1];
        sb = op_signed & b[W-1];
        if (sa) mag_a = -a;
        if (sb) mag_b = -b;
`endif
        mul_sum   = {1'b0, acc_q[2*W-1:W]}
                  + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        fixed     = acc_q;
`ifdef MDU_SIGNED_EN
        if (div_q) begin
            if (neg_q)  fixed[W-1:0]   = -acc_q[W-1:0];
            if (rneg_q) fixed[2*W-1:W] = -acc_q[2*W-1:W];
        end else if (neg_q) begin
            fixed = -acc_q;
        end
        if (op_div_run()) step = '0;
`endif
        if (div_mode()) begin
            if (!div_diff[W])
                step = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
            else
                step = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
        end else begin
            step = {mul_sum, acc_q[W-1:1]};
        end
    end

    // Next-state, datapath and registered-output selection
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        accept   = 1'b0;
`ifdef MDU_SIGNED_EN
        div_d    = div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
`endif
        unique case (state_q)
            IDLE: accept = start;
            RUN: begin
                acc_d = step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) state_d = FIX;
            end
            FIX: begin
                result_d = fixed;
                state_d  = DONE;
            end
            DONE: begin
                accept  = start;
                state_d = IDLE;
            end
        endcase
        if (accept) begin
            state_d = RUN;
            cnt_d   = '0;
            acc_d   = {{W{1'b0}}, op_div ? mag_a : mag_b};
            opnd_d  = op_div ? mag_b : mag_a;
`ifdef MDU_SIGNED_EN
            div_d   = op_div;
            neg_d   = sa ^ sb;
            rneg_d  = sa;
`endif
        end
        busy_d  = (state_d == RUN) || (state_d == FIX);
        ready_d = (state_d == DONE);
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
`ifdef MDU_SIGNED_EN
            div_q    <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
`ifdef MDU_SIGNED_EN
            div_q    <= div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
`endif
        end
    end

    // Operation kind held across RUN for the iteration mux
    logic mode_q;
    always_ff @(posedge clk) begin
        if (rst)         mode_q <= 1'b0;
        else if (accept) mode_q <= op_div;
    end

    function automatic logic div_mode();
        return mode_q;
    endfunction

`ifdef MDU_SIGNED_EN
    function automatic logic op_div_run();
        return 1'b0;
    endfunction
`endif

    assign busy   = busy_q;
    assign ready  = ready_q;
    assign result = result_q;

endmodule
